div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Sequencer for the integer divide/remainder path (DIV, DIVU, REM, REMU) used by the execute stage. It accepts a level-held go request with operands, handles the RISC-V corner cases directly, and otherwise runs a multi-cycle restoring-division datapath. It applies sign fixup, then holds the result until the execute stage acknowledges it. It uses the same go/done stall contract as the multiplier: the execute stage stalls while go & ~done, and csr_kill aborts the operation.

Parameters:
BITS_PER_CYCLE, 1, quotient bits produced per ITER cycle; legal values 1, 2, 4; iteration count = 32/BITS_PER_CYCLE.

Ports:
clk_core  input  1  core clock; all state updates on rising edge
reset_n  input  1  reset, synchronous, active-low
go  input  1  request; level-held by execute until done & ack
kill  input  1  abort (csr_kill); highest priority
is_rem  input  1  1 = return remainder, 0 = return quotient
is_unsigned  input  1  1 = DIVU/REMU, 0 = DIV/REM
dividend  input  32  op1; sampled only in IDLE when go=1
divisor  input  32  op2; sampled only in IDLE when go=1
ack  input  1  execute stage advancing (~ex_stall condition excluding div); consumes result
busy  output  1  state != IDLE
done  output  1  high in DONE state only
result  output  32  valid while done=1; holds last value otherwise

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared.
- kill=1 at posedge: state→IDLE, done=0 next cycle from any state. Has priority over go, ack and reset-free transitions. result is not cleared.
- Cycle numbering: cycle 0 is the first cycle go=1 is seen in IDLE.
- IDLE, go=1, kill=0:
  - Latch operands, is_rem, is_unsigned.
  - Record sign_q = ~is_unsigned & (dividend[31]^divisor[31]) and sign_r = ~is_unsigned & dividend[31].
  - Latch magnitudes (two's-complement negate when signed and negative; -2^31 stays 0x80000000 as unsigned magnitude).
  - Go to PREP.
- PREP, cycle 1:
  - divisor==0: quotient=0xFFFFFFFF, remainder=dividend (original value) → DONE.
  - Signed, dividend==0x80000000, divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0 → DONE.
  - Otherwise: clear partial remainder, counter=0 → ITER.
- ITER, cycles 2..1+32/B:
  - Each cycle performs BITS_PER_CYCLE restoring steps MSB-first: shift {rem, quo} left 1, trial-subtract the divisor magnitude (33-bit compare), set the quotient LSB if non-negative.
  - Counter increments; wraps to 0 on the last iteration → FIXUP.
- FIXUP, cycle 2+32/B:
  - Negate quotient if sign_q; negate remainder if sign_r.
  - Select by is_rem into result → DONE.
- DONE, cycle 3+32/B (35 for B=1, 11 for B=4); corner cases reach DONE at cycle 2:
  - done=1, result stable.
  - ack=1 → IDLE; done drops the next cycle.
  - ack=0 → stay in DONE (downstream stall). go remaining high in DONE is not a new request.
- New request: back-to-back operations start earliest the cycle after leaving DONE (IDLE sees go again).
- go deasserted mid-operation without kill: the operation completes. This is a protocol error; an assertion flags it under non-SYNTHESIS.
- Operand changes after the IDLE sampling edge are ignored.
- busy=1 in PREP, ITER, FIXUP and DONE.

Test Plan:
- DIVU 100/7, B=1, ack=1 at done → done first high at cycle 35, result=14; busy drops the next cycle; done is a single-cycle pulse.
- REM -7 % 2 (0xFFFFFFF9, 2), signed → result=0xFFFFFFFF (-1). DIV same operands → 0xFFFFFFFD (-3).
- DIV x/0 with dividend 0x1234 → done at cycle 2, result=0xFFFFFFFF. REMU 0x1234/0 → result=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF → done at cycle 2, result=0x80000000. REM same → 0. DIVU same → 0.
- Stall hold: ack held 0 for 5 cycles at done → done and result remain stable for 5 cycles, no restart. ack=1 → IDLE. Then a new go with 9/3 → result=3 after the full latency.
- kill at cycle 10 of a DIVU → IDLE next cycle, done never asserted. Immediately issue go with 50/5 → correct 10. Reset asserted mid-ITER → busy=0, done=0, result=0 the next cycle.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Handshake and operand bundle between the execute stage (master) and the divider (slave).
interface div_ctrl_if;
  logic        go;
  logic        kill;
  logic        is_rem;
  logic        is_unsigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ack;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output go, kill, is_rem, is_unsigned, dividend, divisor, ack,
    input  busy, done, result
  );

  modport slave (
    input  go, kill, is_rem, is_unsigned, dividend, divisor, ack,
    output busy, done, result
  );
endinterface

// File: rtl/div_ctrl.sv
// DIV/DIVU/REM/REMU sequencer: RISC-V corner cases, restoring division on magnitudes,
// sign fixup, and a result held until the execute stage acknowledges it.
//   state   | meaning
//   S_IDLE  | waiting for go; operands sampled here
//   S_PREP  | divide-by-zero / signed-overflow shortcut, else start iterating
//   S_ITER  | BITS_PER_CYCLE restoring steps per cycle
//   S_FIXUP | apply result signs, select quotient or remainder
//   S_DONE  | result valid, wait for ack
module div_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic      clk_core,
  input  logic      reset_n,
  div_ctrl_if.slave bus
);
  localparam int         NITER    = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(NITER - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_mag_q, dsr_mag_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] result_q, result_d;
  logic        sign_q_q, sign_q_d;
  logic        sign_r_q, sign_r_d;
  logic        is_rem_q, is_rem_d;
  logic        uns_q, uns_d;

  logic [31:0] step_rem, step_quo;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  // The shifted partial remainder can reach 33 bits, so the trial compare is 33 wide.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    trial    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial    = {step_rem, step_quo[31]};
      step_quo = {step_quo[30:0], 1'b0};
      if (trial >= {1'b0, dsr_mag_q}) begin
        trial       = trial - {1'b0, dsr_mag_q};
        step_quo[0] = 1'b1;
      end
      step_rem = trial[31:0];
    end
  end

  assign quo_fix = sign_q_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = sign_r_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_mag_d = dsr_mag_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    result_d  = result_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    is_rem_d  = is_rem_q;
    uns_d     = uns_q;
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.go) begin
          dvd_d     = bus.dividend;
          dsr_d     = bus.divisor;
          is_rem_d  = bus.is_rem;
          uns_d     = bus.is_unsigned;
          sign_q_d  = ~bus.is_unsigned & (bus.dividend[31] ^ bus.divisor[31]);
          sign_r_d  = ~bus.is_unsigned & bus.dividend[31];
          quo_d     = (~bus.is_unsigned & bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
          dsr_mag_d = (~bus.is_unsigned & bus.divisor[31]) ? (~bus.divisor + 32'd1) : bus.divisor;
          state_d   = S_PREP;
        end
        S_PREP: begin
          if (dsr_q == 32'd0) begin
            result_d = is_rem_q ? dvd_q : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (!uns_q && dvd_q == 32'h8000_0000 && dsr_q == 32'hFFFF_FFFF) begin
            result_d = is_rem_q ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_FIXUP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_FIXUP: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
        S_DONE: if (bus.ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_mag_q <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      result_q  <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      uns_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_mag_q <= dsr_mag_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      result_q  <= result_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      is_rem_q  <= is_rem_d;
      uns_q     <= uns_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

`ifndef SYNTHESIS
  // Execute must hold go until done & ack; dropping it early is a protocol error.
  go_held_a: assert property (@(posedge clk_core) disable iff (!reset_n)
    ((state_q inside {S_PREP, S_ITER, S_FIXUP}) && !bus.kill) |-> bus.go)
    else $error("div_ctrl: go dropped mid-operation");
`endif
endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
  localparam int B   = 1;
  localparam int LAT = 3 + 32 / B;

  logic clk_core;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_ctrl_if bus ();

  div_ctrl #(.BITS_PER_CYCLE(B)) dut (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  function automatic logic is_corner(input logic [31:0] a, input logic [31:0] b, input logic u);
    return (b == 32'd0) || (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic r, input logic u);
    logic [31:0] q, m;
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; m = a;
    end else if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; m = 32'd0;
    end else if (u) begin
      q = a / b; m = a % b;
    end else begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); m = 32'(sa % sb);
    end
    return r ? m : q;
  endfunction

  // Issues one request, waits for done, optionally stalls ack, then acknowledges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic r, input logic u,
                        input int hold, output logic [31:0] res, output int lat,
                        output logic stable, output logic busy_after, output logic done_after);
    bus.dividend = a; bus.divisor = b; bus.is_rem = r; bus.is_unsigned = u; bus.go = 1'b1;
    lat = -1; stable = 1'b1; res = '0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk_core); #1;
      if (bus.done) begin lat = c; break; end
    end
    if (lat < 0) begin
      bus.kill = 1'b1; @(posedge clk_core); #1; bus.kill = 1'b0; bus.go = 1'b0;
      busy_after = bus.busy; done_after = bus.done;
      return;
    end
    res = bus.result;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_core); #1;
      if (!bus.done || bus.result !== res) stable = 1'b0;
    end
    bus.ack = 1'b1;
    @(posedge clk_core); #1;
    bus.ack = 1'b0; bus.go = 1'b0;
    busy_after = bus.busy; done_after = bus.done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_core);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    reset_n = 1'b1;
    @(posedge clk_core); #1;
  endtask

  task automatic test_latency();
    logic [31:0] res; int lat; logic st, ba, da;
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 0, res, lat, st, ba, da);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL divu_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL divu_result: got %h expected %h", res, 32'd14); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL divu_busy_after: got %b expected 0", ba); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL divu_done_pulse: got %b expected 0", da); end
  endtask

  task automatic test_signed();
    logic [31:0] res; int lat; logic st, ba, da;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rem_neg: got %h expected ffffffff", res); end
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg: got %h expected fffffffd", res); end
  endtask

  task automatic test_corners();
    logic [31:0] res; int lat; logic st, ba, da;
    run_op(32'h1234, 32'd0, 1'b0, 1'b0, 0, res, lat, st, ba, da);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL div0_latency: got %0d expected 2", lat); end
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_result: got %h expected ffffffff", res); end
    run_op(32'h1234, 32'd0, 1'b1, 1'b1, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'h1234) begin n_bad++; $display("FAIL remu0_result: got %h expected 00001234", res); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, res, lat, st, ba, da);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
    n_cmp++; if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_div: got %h expected 80000000", res); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'd0) begin n_bad++; $display("FAIL ovf_rem: got %h expected 0", res); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'd0) begin n_bad++; $display("FAIL ovf_divu: got %h expected 0", res); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL ovf_divu_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_stall();
    logic [31:0] res; int lat; logic st, ba, da;
    run_op(32'd1000, 32'd33, 1'b0, 1'b1, 5, res, lat, st, ba, da);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL stall_stable: got %b expected 1", st); end
    n_cmp++; if (res !== 32'd30) begin n_bad++; $display("FAIL stall_result: got %h expected %h", res, 32'd30); end
    n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL stall_idle_after_ack: got %b expected 0", ba); end
    run_op(32'd9, 32'd3, 1'b0, 1'b1, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL after_stall_result: got %h expected 3", res); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL after_stall_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_kill_reset();
    logic [31:0] res; int lat; logic st, ba, da, seen;
    bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.is_rem = 1'b0; bus.is_unsigned = 1'b1; bus.go = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_core); #1;
      if (bus.done) seen = 1'b1;
    end
    bus.kill = 1'b1;
    @(posedge clk_core); #1;
    bus.kill = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_busy: got %b expected 0", bus.busy); end
    n_cmp++; if ((seen | bus.done) !== 1'b0) begin n_bad++; $display("FAIL kill_done_seen: got %b expected 0", seen | bus.done); end
    run_op(32'd50, 32'd5, 1'b0, 1'b1, 0, res, lat, st, ba, da);
    n_cmp++; if (res !== 32'd10) begin n_bad++; $display("FAIL after_kill_result: got %h expected a", res); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL after_kill_latency: got %0d expected %0d", lat, LAT); end
    bus.dividend = 32'd77; bus.divisor = 32'd4; bus.go = 1'b1;
    repeat (10) @(posedge clk_core);
    #1;
    reset_n = 1'b0;
    @(posedge clk_core); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL midreset_result: got %h expected 0", bus.result); end
    reset_n = 1'b1; bus.go = 1'b0;
    @(posedge clk_core); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_res; logic r, u, st, ba, da; int lat, exp_lat;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; b = $urandom; r = 1'($urandom); u = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      exp_res = ref_result(a, b, r, u);
      exp_lat = is_corner(a, b, u) ? 2 : LAT;
      run_op(a, b, r, u, 0, res, lat, st, ba, da);
      n_cmp++; if (res !== exp_res) begin n_bad++;
        $display("FAIL rand_result a=%h b=%h rem=%b uns=%b: got %h expected %h", a, b, r, u, res, exp_res); end
      n_cmp++; if (lat !== exp_lat) begin n_bad++;
        $display("FAIL rand_latency a=%h b=%h: got %0d expected %0d", a, b, lat, exp_lat); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.go = 1'b0; bus.kill = 1'b0; bus.is_rem = 1'b0; bus.is_unsigned = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.ack = 1'b0;
    test_reset();
    test_latency();
    test_signed();
    test_corners();
    test_stall();
    test_kill_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
